// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable width, parity and stop bits.
// Holds one word behind valid/ready and flags parity, framing and overrun errors.
module uart_rx_cfg #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic                 in_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY == 1);
    localparam logic          STOP_END = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t                 state_q;
    logic                   sync1_q, sync2_q, prev_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic                   stop_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   perr_q, ferr_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q, perr_out_q, ferr_out_q, ovr_q;

    logic edge_det, fall, resync, at_mid, bit_end, stop_last, complete;
    logic perr_d, ferr_d;

    assign edge_det  = en_i && (sync2_q != prev_q);
    assign fall      = edge_det && !sync2_q;
    // An edge in the late half of a bit means the next bit already started.
    assign resync    = edge_det && (cnt_q < CNT_MID);
    assign at_mid    = en_i && (cnt_q == CNT_MID);
    assign bit_end   = (en_i && (cnt_q == '0)) || resync;
    assign stop_last = (stop_idx_q == STOP_END);
    assign complete  = at_mid && (state_q == S_STOP) && stop_last;
    assign perr_d    = ((sync2_q ^ (^shift_q)) != PAR_ODD);
    assign ferr_d    = ferr_q | ~sync2_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            prev_q     <= 1'b1;
            cnt_q      <= CNT_LOAD;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (en_i) begin
            prev_q <= sync2_q;
            if (state_q != S_IDLE && state_q != S_BREAK)
                cnt_q <= bit_end ? CNT_LOAD : cnt_q - CW'(1);
            case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        state_q <= S_START;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                S_START: begin
                    if (at_mid && sync2_q) begin
                        state_q <= S_IDLE;
                    end else if (bit_end) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (at_mid)
                        shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (idx_q == IDX_LAST) begin
                            state_q    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (at_mid)
                        perr_q <= perr_d;
                    if (bit_end) begin
                        state_q    <= S_STOP;
                        stop_idx_q <= 1'b0;
                    end
                end
                S_STOP: begin
                    // Finishing at the last sample point leaves half a bit to catch the next start edge.
                    if (at_mid) begin
                        ferr_q <= ferr_d;
                        if (stop_last)
                            state_q <= ferr_d ? S_BREAK : S_IDLE;
                    end else if (bit_end) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                S_BREAK: begin
                    if (sync2_q)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || ready_i) begin
                    data_q     <= shift_q;
                    perr_out_q <= perr_q;
                    ferr_out_q <= ferr_d;
                    valid_q    <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_out_q;
    assign frame_err_o  = ferr_out_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 9O2) driven with serial frames;
// delivered words are checked against expectations computed from the frame contents.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] en = 3'b111;
    logic [2:0] line = 3'b111;
    logic [2:0] rdy = 3'b111;
    wire  [2:0] vld, perr, ferr, ovr, bsy;
    wire  [7:0] dat_a, dat_b;
    wire  [8:0] dat_c;

    int n_cmp = 0;
    int n_bad = 0;
    int dbits    [3] = '{8, 8, 9};
    int pmode    [3] = '{0, 2, 1};
    int nstop    [3] = '{1, 1, 2};
    int ediv     [3] = '{1, 2, 3};
    int ecnt     [3] = '{0, 0, 0};
    int exp_ovr  [3] = '{0, 0, 0};
    int ovr_seen [3] = '{0, 0, 0};
    logic [10:0] q0 [$];
    logic [10:0] q1 [$];
    logic [10:0] q2 [$];

    always #5 clk = ~clk;

    uart_rx_cfg #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .reset_i(rst), .en_i(en[0]), .in_i(line[0]), .data_o(dat_a),
        .valid_o(vld[0]), .ready_i(rdy[0]), .parity_err_o(perr[0]), .frame_err_o(ferr[0]),
        .overrun_o(ovr[0]), .busy_o(bsy[0]));
    uart_rx_cfg #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk_i(clk), .reset_i(rst), .en_i(en[1]), .in_i(line[1]), .data_o(dat_b),
        .valid_o(vld[1]), .ready_i(rdy[1]), .parity_err_o(perr[1]), .frame_err_o(ferr[1]),
        .overrun_o(ovr[1]), .busy_o(bsy[1]));
    uart_rx_cfg #(.OVERSAMPLE(16), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk_i(clk), .reset_i(rst), .en_i(en[2]), .in_i(line[2]), .data_o(dat_c),
        .valid_o(vld[2]), .ready_i(rdy[2]), .parity_err_o(perr[2]), .frame_err_o(ferr[2]),
        .overrun_o(ovr[2]), .busy_o(bsy[2]));

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] dat(input int i);
        case (i)
            0:       return {1'b0, dat_a};
            1:       return {1'b0, dat_b};
            default: return dat_c;
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void qpush(input int i, input logic [10:0] e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic logic [10:0] qpop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Oversample ticks: instance i sees en high every ediv[i] clocks.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 3; i++) begin
                ecnt[i] = (ecnt[i] + 1) % ediv[i];
                en[i]   = (ecnt[i] == 0);
            end
        end
    end

    // Consumer side: every accepted word must be the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ovr[i]) ovr_seen[i]++;
                if (vld[i] && rdy[i]) begin
                    if (qsize(i) == 0)
                        check_eq($sformatf("word_expected%0d", i), qsize(i), 1);
                    else
                        check_eq($sformatf("word%0d", i), {ferr[i], perr[i], dat(i)}, qpop(i));
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int i, input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (en[i]) k++;
        end
        #2;
    endtask

    task automatic drive(input int i, input logic v, input int n);
        line[i] = v;
        ticks(i, n);
    endtask

    task automatic send(input int i, input logic [8:0] d, input int tpb, input bit flip,
                        input bit bad_stop, input int extra_low);
        logic [8:0] dm;
        logic pb;
        bit   has_par;
        dm      = d & 9'((1 << dbits[i]) - 1);
        has_par = (pmode[i] != 0);
        pb      = (^dm) ^ (pmode[i] == 1) ^ flip;
        if (qsize(i) > 0 && !rdy[i]) exp_ovr[i]++;
        else qpush(i, {bad_stop, flip && has_par, dm});
        align();
        drive(i, 1'b0, tpb);
        for (int k = 0; k < dbits[i]; k++) drive(i, dm[k], tpb);
        if (has_par) drive(i, pb, tpb);
        for (int s = 0; s < nstop[i]; s++) drive(i, !bad_stop, tpb);
        if (bad_stop && extra_low > 0) drive(i, 1'b0, extra_low);
    endtask

    task automatic frame(input int i, input logic [8:0] d, input int tpb, input bit flip);
        send(i, d, tpb, flip, 1'b0, 0);
        drive(i, 1'b1, tpb);
    endtask

    initial begin
        logic [8:0] part;
        #500000;
        check_eq("watchdog", 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] part;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_flags%0d", i), {vld[i], perr[i], ferr[i], ovr[i], bsy[i]}, 0);
            check_eq($sformatf("rst_data%0d", i), dat(i), 0);
        end
        align();
        rst = 1'b0;
        ticks(0, 8);

        // 8N1 basic and random words
        frame(0, 9'h0A5, 16, 1'b0);
        check_eq("a5_delivered", qsize(0), 0);
        for (int n = 0; n < 8; n++) frame(0, 9'($urandom_range(0, 255)), 16, 1'b0);

        // Stop bit low: framing error, then line parked low
        send(0, 9'h055, 16, 1'b0, 1'b1, 24);
        @(negedge clk);
        check_eq("break_busy", bsy[0], 1);
        check_eq("ferr_delivered", qsize(0), 0);
        align();
        drive(0, 1'b1, 16);
        @(negedge clk);
        check_eq("break_exit", bsy[0], 0);
        frame(0, 9'($urandom_range(0, 255)), 16, 1'b0);

        // 3-tick low glitch from idle
        align();
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 1);
        @(negedge clk);
        check_eq("glitch_start", bsy[0], 1);
        ticks(0, 8);
        @(negedge clk);
        check_eq("glitch_rejected", bsy[0], 0);
        ticks(0, 16);

        // Overrun: consumer stalled across two frames
        align();
        rdy[0] = 1'b0;
        frame(0, 9'h011, 16, 1'b0);
        @(negedge clk);
        check_eq("held_valid", vld[0], 1);
        check_eq("held_data", dat(0), 9'h011);
        frame(0, 9'h022, 16, 1'b0);
        @(negedge clk);
        check_eq("overrun_pulses", ovr_seen[0], 1);
        check_eq("held_data_kept", dat(0), 9'h011);
        align();
        rdy[0] = 1'b1;
        ticks(0, 4);
        frame(0, 9'h033, 16, 1'b0);

        // Reset in the middle of data bit 4
        part = 9'h0C3;
        align();
        drive(0, 1'b0, 16);
        for (int k = 0; k < 4; k++) drive(0, part[k], 16);
        drive(0, part[4], 8);
        rst     = 1'b1;
        line[0] = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", bsy[0], 0);
        check_eq("midrst_valid", vld[0], 0);
        align();
        rst = 1'b0;
        ticks(0, 16);
        frame(0, 9'h07E, 16, 1'b0);

        // 8E1: forced parity error, then correct parity, then random
        frame(1, 9'h003, 16, 1'b1);
        frame(1, 9'h003, 16, 1'b0);
        for (int n = 0; n < 6; n++)
            frame(1, 9'($urandom_range(0, 255)), 16, 1'($urandom_range(0, 1)));

        // 9O2 at en/3, fast line (15 ticks per bit), then random at nominal rate
        frame(2, 9'h1A3, 15, 1'b0);
        for (int n = 0; n < 4; n++) frame(2, 9'($urandom_range(0, 511)), 16, 1'b0);

        ticks(0, 16);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("pending%0d", i), qsize(i), 0);
            check_eq($sformatf("overruns%0d", i), ovr_seen[i], exp_ovr[i]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
